// File: rtl/fifo_frame_reader.sv
// Frame reader: pulls header-prefixed frames from a normal-mode single-clock FIFO,
// drops the header, and streams payload words with sop/eop through a 2-entry skid buffer.
module fifo_frame_reader #(
    parameter int MAX_LEN = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic [15:0] out_len,
    output logic [31:0] frame_count,
    output logic        len_err,
    output logic        dbg_state
);

    localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

    typedef enum logic {
        HDR = 1'b0,
        PAY = 1'b1
    } state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [15:0] len;
        logic        sop;
        logic        eop;
    } entry_t;

    state_t      state, state_next;
    logic [15:0] remaining, remaining_next;
    logic [15:0] frame_len, frame_len_next;
    logic        first, first_next;
    logic        inflight;
    logic        err_next;

    entry_t      slot0, slot1, slot0_next, slot1_next, push_entry;
    logic [1:0]  count, count_next;
    logic        push, pop, head_load;
    logic [2:0]  pending;
    logic [15:0] hdr_n;
    logic        hdr_ok;

    // Handshake: a word moves downstream in any cycle where out_valid && out_ready;
    // head entry is held unchanged otherwise.
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? slot0.data : 64'd0;
    assign out_sop   = out_valid && slot0.sop;
    assign out_eop   = out_valid && slot0.eop;
    assign dbg_state = (state == PAY);

    // Credit counts the slot freed by this cycle's pop so a steady stream runs at one word per cycle.
    assign pending    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rdreq = !reset && !fifo_empty && (pending < 3'd2);

    assign hdr_n  = fifo_q[15:0];
    assign hdr_ok = (hdr_n != 16'd0) && ({1'b0, hdr_n} <= MAX_LEN_W);

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        frame_len_next = frame_len;
        first_next     = first;
        err_next       = 1'b0;
        push           = 1'b0;
        push_entry     = '0;
        if (inflight) begin
            case (state)
                HDR: begin
                    if (hdr_ok) begin
                        remaining_next = hdr_n;
                        frame_len_next = hdr_n;
                        first_next     = 1'b1;
                        state_next     = PAY;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                PAY: begin
                    push            = 1'b1;
                    push_entry.data = fifo_q;
                    push_entry.len  = frame_len;
                    push_entry.sop  = first;
                    push_entry.eop  = (remaining == 16'd1);
                    remaining_next  = remaining - 16'd1;
                    first_next      = 1'b0;
                    if (remaining == 16'd1) begin
                        state_next = HDR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        slot0_next = slot0;
        slot1_next = slot1;
        count_next = count;
        case ({push, pop})
            2'b10: begin
                if (count == 2'd0) begin
                    slot0_next = push_entry;
                end else begin
                    slot1_next = push_entry;
                end
                count_next = count + 2'd1;
            end
            2'b01: begin
                slot0_next = slot1;
                count_next = count - 2'd1;
            end
            2'b11: begin
                if (count == 2'd1) begin
                    slot0_next = push_entry;
                end else begin
                    slot0_next = slot1;
                    slot1_next = push_entry;
                end
            end
            default: ;
        endcase
    end

    // out_len only follows a new head entry that starts a frame.
    assign head_load = (push && (count == 2'd0)) || (pop && (count_next != 2'd0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HDR;
            remaining   <= '0;
            frame_len   <= '0;
            first       <= 1'b0;
            inflight    <= 1'b0;
            slot0       <= '0;
            slot1       <= '0;
            count       <= '0;
            out_len     <= '0;
            frame_count <= '0;
            len_err     <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            frame_len <= frame_len_next;
            first     <= first_next;
            inflight  <= fifo_rdreq;
            slot0     <= slot0_next;
            slot1     <= slot1_next;
            count     <= count_next;
            len_err   <= err_next;
            if (head_load && slot0_next.sop) begin
                out_len <= slot0_next.len;
            end
            if (pop && slot0.eop) begin
                frame_count <= frame_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: FIFO model, directed frames and random traffic,
// checked every cycle against a stream-level frame model.
module tb_fifo_frame_reader;

    localparam int MAX_LEN = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic [15:0] out_len;
    logic [31:0] frame_count;
    logic        len_err;
    logic        dbg_state;

    always #5 clk = ~clk;

    fifo_frame_reader #(.MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset(reset), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
        .fifo_rdreq(fifo_rdreq), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop), .out_len(out_len),
        .frame_count(frame_count), .len_err(len_err), .dbg_state(dbg_state)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [63:0] fifo_mem[$];
    logic [63:0] pend[$];
    logic [81:0] exp_q[$];   // {data, len, sop, eop}

    int model_frames, model_len_err, seen_len_err, accepted_words;
    int p_rem;
    logic p_first;
    logic [15:0] p_len;
    int ready_mode, wr_prob, scen_cyc, first_valid_cyc, last_eop_cyc;
    logic [63:0] last_data;
    logic [1:0]  last_flags;
    logic [15:0] last_sop_len;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Frame rules applied to the raw word stream entering the FIFO.
    function automatic void model_word(input logic [63:0] w);
        if (p_rem == 0) begin
            if (w[15:0] == 16'd0 || int'(w[15:0]) > MAX_LEN) begin
                model_len_err++;
            end else begin
                p_rem   = int'(w[15:0]);
                p_len   = w[15:0];
                p_first = 1'b1;
            end
        end else begin
            exp_q.push_back({w, p_len, p_first, (p_rem == 1)});
            p_first = 1'b0;
            p_rem--;
        end
    endfunction

    task automatic load_word(input logic [63:0] w);
        fifo_mem.push_back(w);
        model_word(w);
        fifo_empty = 1'b0;
    endtask

    task automatic queue_word(input logic [63:0] w);
        pend.push_back(w);
        model_word(w);
    endtask

    task automatic begin_scen();
        scen_cyc        = 0;
        first_valid_cyc = -1;
        last_eop_cyc    = -1;
        accepted_words  = 0;
        seen_len_err    = 0;
        model_len_err   = 0;
        last_data       = '0;
        last_flags      = '0;
        last_sop_len    = '0;
    endtask

    // One clock cycle; entered and left just after a rising edge.
    task automatic step();
        logic        rd;
        logic [81:0] e;
        @(negedge clk);
        cyc++;
        scen_cyc++;
        if (len_err) seen_len_err++;
        chk("frame_count", 64'(frame_count), 64'(model_frames));
        if (out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q[0];
                chk("out_data", out_data, e[81:18]);
                chk("out_sop", 64'(out_sop), 64'(e[1]));
                chk("out_eop", 64'(out_eop), 64'(e[0]));
                chk("out_len", 64'(out_len), 64'(e[17:2]));
            end
        end else begin
            chk("idle_data", out_data, 64'd0);
            chk("idle_flags", 64'({out_sop, out_eop}), 64'd0);
        end
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (scen_cyc <= 10) ? 1'b0 : 1'(scen_cyc % 2);
        endcase
        if (out_valid && out_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            accepted_words++;
            last_data  = out_data;
            last_flags = {out_sop, out_eop};
            if (out_sop) last_sop_len = out_len;
            if (e[0]) begin
                model_frames++;
                last_eop_cyc = cyc;
            end
        end
        if (pend.size() > 0 && fifo_mem.size() < 256 && int'($urandom_range(0, 99)) < wr_prob) begin
            fifo_mem.push_back(pend.pop_front());
        end
        fifo_empty = (fifo_mem.size() == 0);
        #1;
        rd = fifo_rdreq;
        if (rd) chk("rdreq_while_empty", 64'(fifo_empty), 64'd0);
        @(posedge clk);
        #1;
        if (rd && fifo_mem.size() > 0) fifo_q = fifo_mem.pop_front();
        fifo_empty = (fifo_mem.size() == 0);
    endtask

    task automatic do_reset(input int cycles);
        reset     = 1'b1;
        out_ready = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            fifo_mem.delete();
            fifo_empty = 1'b1;
        end
        chk("rst_valid_flags", 64'({out_valid, out_sop, out_eop, len_err, fifo_rdreq, dbg_state}), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_len", 64'(out_len), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        exp_q.delete();
        pend.delete();
        model_frames = 0;
        p_rem        = 0;
        p_first      = 1'b0;
        p_len        = '0;
        reset        = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int idle = 0;
        int c = 0;
        while (idle < 4 && c < budget) begin
            step();
            c++;
            if (pend.size() == 0 && fifo_mem.size() == 0 && exp_q.size() == 0 && !out_valid) idle++;
            else idle = 0;
        end
        chk("drain", 64'(exp_q.size() + fifo_mem.size() + pend.size() + int'(out_valid)), 64'd0);
    endtask

    task automatic gen_frames(input int n);
        logic [15:0] n_len;
        int sel;
        for (int f = 0; f < n; f++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       n_len = 16'd0;
                1:       n_len = ($urandom_range(0, 1) == 0) ? 16'(MAX_LEN + 1) : 16'hFFFF;
                2:       n_len = 16'd1;
                3:       n_len = 16'(MAX_LEN);
                default: n_len = 16'($urandom_range(1, MAX_LEN));
            endcase
            queue_word({$urandom, 16'($urandom), n_len});
            if (n_len != 16'd0 && int'(n_len) <= MAX_LEN) begin
                for (int k = 0; k < int'(n_len); k++) queue_word({$urandom, $urandom});
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        out_ready  = 1'b0;
        fifo_q     = '0;
        fifo_empty = 1'b1;
        ready_mode = 0;
        wr_prob    = 100;
        do_reset(3);

        // Three-word frame at full rate.
        begin_scen();
        ready_mode = 0;
        load_word(64'd3); load_word(64'd1); load_word(64'd2); load_word(64'd3);
        run_until_idle(100);
        chk("t3_frames", 64'(frame_count), 64'd1);
        chk("t3_span", 64'(last_eop_cyc - first_valid_cyc + 1), 64'd3);
        chk("t3_len", 64'(last_sop_len), 64'd3);

        // Single-word frame.
        do_reset(1);
        begin_scen();
        load_word(64'd1); load_word(64'hAA);
        run_until_idle(100);
        chk("t1_frames", 64'(frame_count), 64'd1);
        chk("t1_data", last_data, 64'hAA);
        chk("t1_sop_eop", 64'(last_flags), 64'd3);

        // Zero-length header rejected; upper header bits are ignored.
        do_reset(1);
        begin_scen();
        load_word(64'hDEAD_0000_0000_0000); load_word(64'hFFFF_0000_0000_0002);
        load_word(64'd5); load_word(64'd6);
        run_until_idle(100);
        chk("n0_len_err", 64'(seen_len_err), 64'd1);
        chk("n0_frames", 64'(frame_count), 64'd1);
        chk("n0_last", last_data, 64'd6);

        // Oversize header rejected.
        do_reset(1);
        begin_scen();
        load_word(64'(MAX_LEN + 1)); load_word(64'd2); load_word(64'd5); load_word(64'd6);
        run_until_idle(100);
        chk("nmax_len_err", 64'(seen_len_err), 64'd1);
        chk("nmax_frames", 64'(frame_count), 64'd1);

        // Backpressure: ready low 10 cycles, then toggling.
        do_reset(1);
        begin_scen();
        ready_mode = 2;
        load_word(64'd4);
        for (int i = 1; i <= 4; i++) load_word(64'(i));
        run_until_idle(200);
        chk("bp_words", 64'(accepted_words), 64'd4);
        chk("bp_frames", 64'(frame_count), 64'd1);
        chk("bp_last", last_data, 64'd4);

        // Three back-to-back N=2 frames: one bubble per later header.
        do_reset(1);
        begin_scen();
        ready_mode = 0;
        for (int f = 0; f < 3; f++) begin
            load_word(64'd2); load_word(64'(16 * f + 1)); load_word(64'(16 * f + 2));
        end
        run_until_idle(100);
        chk("b2b_frames", 64'(frame_count), 64'd3);
        chk("b2b_span", 64'(last_eop_cyc - first_valid_cyc + 1), 64'd8);
        chk("b2b_words", 64'(accepted_words), 64'd6);

        // Reset in the middle of an N=5 frame, then a fresh single-word frame.
        do_reset(1);
        begin_scen();
        load_word(64'd5);
        for (int i = 1; i <= 5; i++) load_word(64'(i));
        for (int c = 0; c < 50 && accepted_words < 2; c++) step();
        chk("mid_partial", 64'(accepted_words), 64'd2);
        do_reset(1);
        begin_scen();
        load_word(64'd1); load_word(64'h77);
        run_until_idle(100);
        chk("mid_frames", 64'(frame_count), 64'd1);
        chk("mid_data", last_data, 64'h77);
        chk("mid_sop_eop", 64'(last_flags), 64'd3);
        chk("mid_words", 64'(accepted_words), 64'd1);

        // Random traffic with random backpressure and bursty writes.
        do_reset(1);
        begin_scen();
        ready_mode = 1;
        wr_prob    = 60;
        gen_frames(40);
        run_until_idle(6000);
        chk("rand_len_err", 64'(seen_len_err), 64'(model_len_err));

        // Random traffic at full rate.
        begin_scen();
        ready_mode = 0;
        wr_prob    = 100;
        gen_frames(30);
        run_until_idle(4000);
        chk("rand_fast_len_err", 64'(seen_len_err), 64'(model_len_err));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_frame_reader.md
FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

Interface
REQ-001 Parameter MAX_LEN, default 1024: largest legal payload length in 64-bit words (1..65535).
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 fifo_q  input  64  read data from the 64x256 single-clock FIFO, valid exactly 1 cycle after fifo_rdreq (normal, non-show-ahead mode).
REQ-005 fifo_empty  input  1  FIFO empty flag.
REQ-006 fifo_rdreq  output  1  read request to FIFO.
REQ-007 out_data  output  64  payload word.
REQ-008 out_valid  output  1  out_data/out_sop/out_eop valid.
REQ-009 out_ready  input  1  downstream accepts the word when out_valid && out_ready.
REQ-010 out_sop  output  1  first payload word of a frame.
REQ-011 out_eop  output  1  last payload word of a frame.
REQ-012 out_len  output  16  payload length N of the frame currently being emitted.
REQ-013 frame_count  output  32  count of frames whose eop word was accepted downstream.
REQ-014 len_err  output  1  one-cycle pulse on a rejected header.

Function
REQ-015 Frame format in FIFO: one header word (bits[15:0] = N, bits[63:16] ignored) followed by N payload words; header is consumed internally, never output.
REQ-016 Parser states: HDR (expecting header) and PAY (expecting payload); reset state HDR.
REQ-017 HDR, word arrives with 1 <= N <= MAX_LEN -> latch N into a remaining counter and out_len, go to PAY, mark next payload word sop.
REQ-018 HDR, word arrives with N == 0 or N > MAX_LEN -> pulse len_err next cycle, drop word, stay HDR.
REQ-019 PAY, word arrives -> push into output buffer with sop (first word) and eop (remaining == 1); decrement remaining; on eop return to HDR.
REQ-020 N == 1: single word carries both out_sop and out_eop.
REQ-021 Output buffer: 2-entry skid FIFO holding {data, sop, eop}; out_valid = buffer non-empty; out_data/sop/eop come from head entry.
REQ-022 Read credit: fifo_rdreq = !fifo_empty && (buffer occupancy + reads in flight) < 2; at most one read in flight (1-cycle latency).
REQ-023 fifo_rdreq never asserted while fifo_empty is high; no FIFO underflow under any out_ready pattern.
REQ-024 Output buffer never overflows; out_data/sop/eop hold stable while out_valid && !out_ready.
REQ-025 Simultaneous push and pop on the buffer in one cycle: occupancy unchanged, order preserved.
REQ-026 Sustained throughput: with FIFO non-empty and out_ready held high, one payload word per cycle after initial 2-cycle latency (rdreq -> data -> out_valid), minus one cycle per header.
REQ-027 out_len holds the value of the frame whose words are at the buffer head; changes only when a sop word reaches head.
REQ-028 frame_count increments by 1 on each accepted eop word; wraps 0xFFFFFFFF -> 0.
REQ-029 fifo_rdreq, out_valid, out_sop, out_eop, len_err are 0 whenever out_valid conditions are absent; no X on outputs after reset.

Reset
REQ-030 reset high at a clock edge: state HDR, buffer empty, in-flight flag cleared, remaining = 0, out_len = 0, frame_count = 0, fifo_rdreq = 0, out_valid = 0, out_sop = 0, out_eop = 0, len_err = 0, out_data = 0.
REQ-031 fifo_rdreq held 0 during reset; a word returned by FIFO the cycle after reset deasserts is discarded if its read was issued before reset.
REQ-032 Reset mid-frame discards the partial frame; the next word read after reset is parsed as a header.

Verification
REQ-033 Write {hdr N=3, 1, 2, 3}, out_ready=1 -> out_data 1(sop),2,3(eop) on consecutive cycles, out_len=3, frame_count=1.
REQ-034 Write {hdr N=1, 0xAA} -> single word 0xAA with out_sop=1 and out_eop=1, frame_count=1.
REQ-035 Write {hdr N=0, hdr N=2, 5, 6} -> one len_err pulse, then 5(sop),6(eop); frame_count=1; repeat with N=MAX_LEN+1 -> same.
REQ-036 Write {hdr N=4, 1..4}, out_ready low 10 cycles then toggling every cycle -> words 1..4 in order, none lost or duplicated, fifo_rdreq never high while fifo_empty.
REQ-037 Write 3 back-to-back frames N=2 with out_ready=1 -> 6 words, sop/eop correct per frame, frame_count=3, one bubble per header.
REQ-038 Assert reset after 2nd payload word of an N=5 frame, then write {hdr N=1, 0x77} -> all outputs zero during reset, then only 0x77 (sop, eop), frame_count=1.
